// File: rtl/pipe_dest_tracker_pkg.sv
// Shared types for the destination-register tracker: the pipe-entry bundle,
// the bubble value and the forwarding select encodings used by consumers.
package pipe_dest_tracker_pkg;

   localparam int REG_AW = 3;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } pipe_entry_t;

   localparam pipe_entry_t BUBBLE = '0;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_MEMWB   = 2'b01,
      FWD_EXMEM   = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/pipe_dest_stage.sv
// One pipeline register for a destination entry; hold beats bubble beats load.
module pipe_dest_stage
   import pipe_dest_tracker_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        bubble,
   input  pipe_entry_t next_entry,
   output pipe_entry_t entry
);

   always_ff @(posedge clk) begin
      if (rst) begin
         entry <= BUBBLE;
      end else if (!hold) begin
         if (bubble) begin
            entry <= BUBBLE;
         end else begin
            entry <= next_entry;
         end
      end
   end

endmodule

// File: rtl/pipe_dest_tracker.sv
// Carries destination/write-enable/load flags through ID/EX, EX/MEM, MEM/WB,
// detects load-use hazards and counts stalled cycles.
module pipe_dest_tracker #(
   parameter int REG_AW       = pipe_dest_tracker_pkg::REG_AW,
   parameter int CNT_W        = 8,
   parameter int R0_HARDWIRED = 0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Id_valid,
   input  logic [REG_AW-1:0] Id_rd,
   input  logic              Id_reg_write,
   input  logic              Id_mem_read,
   input  logic [REG_AW-1:0] Id_rs,
   input  logic [REG_AW-1:0] Id_rt,
   input  logic              Id_uses_rt,
   input  logic              Flush,
   input  logic              Mem_busy,
   output logic [REG_AW-1:0] Idex_rd,
   output logic              Idex_reg_write,
   output logic              Idex_mem_read,
   output logic [REG_AW-1:0] Exmem_rd,
   output logic              Exmem_reg_write,
   output logic [REG_AW-1:0] Memwb_rd,
   output logic              Memwb_reg_write,
   output logic              Stall,
   output logic [CNT_W-1:0]  Stall_count
);

   import pipe_dest_tracker_pkg::*;

   pipe_entry_t idex;
   pipe_entry_t exmem;
   pipe_entry_t memwb;
   pipe_entry_t id_entry;
   logic        load_use;

   // A load in EX whose result the decode instruction needs cannot be forwarded in time.
   assign load_use = Id_valid & idex.mem_read & idex.reg_write &
                     ((idex.rd == Id_rs) | (Id_uses_rt & (idex.rd == Id_rt)));

   assign Stall = Mem_busy | (load_use & ~Flush);

   always_comb begin
      id_entry.rd        = Id_rd;
      id_entry.reg_write = Id_reg_write & Id_valid;
      id_entry.mem_read  = Id_mem_read & Id_valid;
      if ((R0_HARDWIRED != 0) && (Id_rd == '0)) begin
         id_entry.reg_write = 1'b0;
         id_entry.mem_read  = 1'b0;
      end
   end

   pipe_dest_stage u_idex (
      .clk        (Clk),
      .rst        (Rst),
      .hold       (Mem_busy),
      .bubble     (Flush | load_use),
      .next_entry (id_entry),
      .entry      (idex)
   );

   pipe_dest_stage u_exmem (
      .clk        (Clk),
      .rst        (Rst),
      .hold       (Mem_busy),
      .bubble     (1'b0),
      .next_entry (idex),
      .entry      (exmem)
   );

   pipe_dest_stage u_memwb (
      .clk        (Clk),
      .rst        (Rst),
      .hold       (Mem_busy),
      .bubble     (1'b0),
      .next_entry (exmem),
      .entry      (memwb)
   );

   assign Idex_rd         = idex.rd;
   assign Idex_reg_write  = idex.reg_write;
   assign Idex_mem_read   = idex.mem_read;
   assign Exmem_rd        = exmem.rd;
   assign Exmem_reg_write = exmem.reg_write;
   assign Memwb_rd        = memwb.rd;
   assign Memwb_reg_write = memwb.reg_write;

   // Saturating: once all-ones the count sticks until reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Stall_count <= '0;
      end else if (Stall && (Stall_count != {CNT_W{1'b1}})) begin
         Stall_count <= Stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed and random stimulus on two tracker instances (r0 writable / r0 hardwired),
// compared each cycle against a small behavioural pipeline model.
module tb_pipe_dest_tracker;

   logic       Clk = 1'b0;
   logic       Rst, Id_valid, Id_reg_write, Id_mem_read, Id_uses_rt, Flush, Mem_busy;
   logic [2:0] Id_rd, Id_rs, Id_rt;

   logic [2:0] a_idex_rd, a_exmem_rd, a_memwb_rd;
   logic       a_idex_w, a_idex_m, a_exmem_w, a_memwb_w, a_stall;
   logic [7:0] a_cnt;
   logic [2:0] b_idex_rd, b_exmem_rd, b_memwb_rd;
   logic       b_idex_w, b_idex_m, b_exmem_w, b_memwb_w, b_stall;
   logic [7:0] b_cnt;

   typedef struct {
      int rd;
      bit wr;
      bit ld;
   } ent_t;

   ent_t mdl[2][3];
   int   mcnt[2];
   bit   known = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 Clk = ~Clk;

   pipe_dest_tracker #(.REG_AW(3), .CNT_W(8), .R0_HARDWIRED(0)) dut (
      .Clk(Clk), .Rst(Rst), .Id_valid(Id_valid), .Id_rd(Id_rd), .Id_reg_write(Id_reg_write),
      .Id_mem_read(Id_mem_read), .Id_rs(Id_rs), .Id_rt(Id_rt), .Id_uses_rt(Id_uses_rt),
      .Flush(Flush), .Mem_busy(Mem_busy),
      .Idex_rd(a_idex_rd), .Idex_reg_write(a_idex_w), .Idex_mem_read(a_idex_m),
      .Exmem_rd(a_exmem_rd), .Exmem_reg_write(a_exmem_w),
      .Memwb_rd(a_memwb_rd), .Memwb_reg_write(a_memwb_w),
      .Stall(a_stall), .Stall_count(a_cnt)
   );

   pipe_dest_tracker #(.REG_AW(3), .CNT_W(8), .R0_HARDWIRED(1)) dut_r0 (
      .Clk(Clk), .Rst(Rst), .Id_valid(Id_valid), .Id_rd(Id_rd), .Id_reg_write(Id_reg_write),
      .Id_mem_read(Id_mem_read), .Id_rs(Id_rs), .Id_rt(Id_rt), .Id_uses_rt(Id_uses_rt),
      .Flush(Flush), .Mem_busy(Mem_busy),
      .Idex_rd(b_idex_rd), .Idex_reg_write(b_idex_w), .Idex_mem_read(b_idex_m),
      .Exmem_rd(b_exmem_rd), .Exmem_reg_write(b_exmem_w),
      .Memwb_rd(b_memwb_rd), .Memwb_reg_write(b_memwb_w),
      .Stall(b_stall), .Stall_count(b_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Compares one instance's outputs against model instance k.
   task automatic checkDut(input int k, input logic [2:0] ird, input logic iw, input logic im,
                           input logic [2:0] erd, input logic ew, input logic [2:0] mrd,
                           input logic mw, input logic st, input logic [7:0] cnt, input bit exp_stall);
      string p;
      p = (k == 0) ? "base" : "r0hw";
      checkOutput({p, "_idex_rd"}, 32'(ird), 32'(mdl[k][0].rd));
      checkOutput({p, "_idex_w"}, 32'(iw), 32'(mdl[k][0].wr));
      checkOutput({p, "_idex_m"}, 32'(im), 32'(mdl[k][0].ld));
      checkOutput({p, "_exmem_rd"}, 32'(erd), 32'(mdl[k][1].rd));
      checkOutput({p, "_exmem_w"}, 32'(ew), 32'(mdl[k][1].wr));
      checkOutput({p, "_memwb_rd"}, 32'(mrd), 32'(mdl[k][2].rd));
      checkOutput({p, "_memwb_w"}, 32'(mw), 32'(mdl[k][2].wr));
      checkOutput({p, "_stall"}, 32'(st), 32'(exp_stall));
      checkOutput({p, "_count"}, 32'(cnt), 32'(mcnt[k]));
   endtask

   // Drives one cycle of inputs, checks both instances, then advances the model by one edge.
   task automatic applyStimulus(input bit rst, input bit v, input int rd, input bit wr, input bit mr,
                                input int rs, input int rt, input bit urt, input bit fl, input bit busy);
      bit   lu[2];
      bit   st[2];
      ent_t incoming;
      @(negedge Clk);
      Rst = rst; Id_valid = v; Id_rd = 3'(rd); Id_reg_write = wr; Id_mem_read = mr;
      Id_rs = 3'(rs); Id_rt = 3'(rt); Id_uses_rt = urt; Flush = fl; Mem_busy = busy;
      #1;
      for (int k = 0; k < 2; k++) begin
         lu[k] = v && mdl[k][0].ld && mdl[k][0].wr &&
                 (mdl[k][0].rd == rs || (urt && mdl[k][0].rd == rt));
         st[k] = busy || (lu[k] && !fl);
      end
      if (known) begin
         checkDut(0, a_idex_rd, a_idex_w, a_idex_m, a_exmem_rd, a_exmem_w, a_memwb_rd, a_memwb_w,
                  a_stall, a_cnt, st[0]);
         checkDut(1, b_idex_rd, b_idex_w, b_idex_m, b_exmem_rd, b_exmem_w, b_memwb_rd, b_memwb_w,
                  b_stall, b_cnt, st[1]);
      end
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int s = 0; s < 3; s++) mdl[k][s] = '{0, 1'b0, 1'b0};
            mcnt[k] = 0;
         end else begin
            if (st[k]) mcnt[k] = (mcnt[k] >= 255) ? 255 : mcnt[k] + 1;
            if (!busy) begin
               incoming = '{rd, wr && v, mr && v};
               if (k == 1 && rd == 0) begin
                  incoming.wr = 1'b0;
                  incoming.ld = 1'b0;
               end
               if (fl || lu[k]) incoming = '{0, 1'b0, 1'b0};
               mdl[k][2] = mdl[k][1];
               mdl[k][1] = mdl[k][0];
               mdl[k][0] = incoming;
            end
         end
      end
      if (rst) known = 1'b1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      Rst = 1'b1; Id_valid = 0; Id_rd = 0; Id_reg_write = 0; Id_mem_read = 0;
      Id_rs = 0; Id_rt = 0; Id_uses_rt = 0; Flush = 0; Mem_busy = 0;

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      checkOutput("reset_idex_w", 32'(a_idex_w), 0);
      checkOutput("reset_stall", 32'(a_stall), 0);
      checkOutput("reset_count", 32'(a_cnt), 0);

      // Straight-line: write r3 travels one stage per edge.
      applyStimulus(0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
      idle();
      checkOutput("flow_idex_rd", 32'(a_idex_rd), 3);
      idle();
      checkOutput("flow_exmem_rd", 32'(a_exmem_rd), 3);
      checkOutput("flow_exmem_w", 32'(a_exmem_w), 1);
      idle();
      checkOutput("flow_memwb_rd", 32'(a_memwb_rd), 3);
      checkOutput("flow_memwb_w", 32'(a_memwb_w), 1);

      // Load r2 followed by a consumer of r2.
      applyStimulus(0, 1, 2, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 1, 0, 2, 5, 1, 0, 0);
      checkOutput("lu_stall", 32'(a_stall), 1);
      applyStimulus(0, 1, 4, 1, 0, 2, 5, 1, 0, 0);
      checkOutput("lu_idex_bubble", 32'(a_idex_w), 0);
      checkOutput("lu_exmem_rd", 32'(a_exmem_rd), 2);
      checkOutput("lu_stall_drop", 32'(a_stall), 0);
      idle();
      checkOutput("lu_memwb_rd", 32'(a_memwb_rd), 2);
      checkOutput("lu_memwb_w", 32'(a_memwb_w), 1);
      checkOutput("lu_count", 32'(a_cnt), 1);

      // Flush beats a pending load-use.
      applyStimulus(0, 1, 2, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 6, 1, 0, 2, 0, 0, 1, 0);
      checkOutput("flush_stall", 32'(a_stall), 0);
      idle();
      checkOutput("flush_idex_w", 32'(a_idex_w), 0);
      checkOutput("flush_exmem_rd", 32'(a_exmem_rd), 2);
      checkOutput("flush_count", 32'(a_cnt), 1);

      // Memory busy freezes for three cycles.
      applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 7, 1, 0, 0, 0, 0, 0, 1);
         checkOutput("busy_stall", 32'(a_stall), 1);
         checkOutput("busy_idex_rd", 32'(a_idex_rd), 5);
      end
      idle();
      checkOutput("busy_count", 32'(a_cnt), 4);

      for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      checkOutput("count_saturate", 32'(a_cnt), 255);

      // Write to r0: only the hardwired instance suppresses it.
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
      idle();
      checkOutput("r0_base_w", 32'(a_idex_w), 1);
      checkOutput("r0_hw_w", 32'(b_idex_w), 0);
      checkOutput("r0_hw_m", 32'(b_idex_m), 0);

      // Reset while memory is busy.
      applyStimulus(0, 1, 3, 1, 1, 0, 0, 0, 0, 1);
      applyStimulus(1, 1, 3, 1, 1, 0, 0, 0, 0, 1);
      idle();
      checkOutput("rst_busy_exmem_w", 32'(a_exmem_w), 0);
      checkOutput("rst_busy_memwb_rd", 32'(a_memwb_rd), 0);
      checkOutput("rst_busy_count", 32'(a_cnt), 0);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(99) < 2), ($urandom_range(99) < 85),
                       int'($urandom_range(7)), ($urandom_range(99) < 80),
                       ($urandom_range(99) < 40), int'($urandom_range(7)),
                       int'($urandom_range(7)), ($urandom_range(99) < 60),
                       ($urandom_range(99) < 10), ($urandom_range(99) < 15));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
